// File: rtl/cfg_fwd_pkg.sv
// Shared types and descriptor field positions for the cfg completion return path.
// Includes the helper that turns an RC completion descriptor into a CC descriptor.
package cfg_fwd_pkg;

    localparam int DESC_W        = 128;
    localparam int LADDR_MSB     = 6;
    localparam int BC_LSB        = 16;
    localparam int BC_MSB        = 28;
    localparam int DWC_LSB       = 32;
    localparam int DWC_MSB       = 42;
    localparam int STATUS_LSB    = 43;
    localparam int STATUS_MSB    = 45;
    localparam int POISON_BIT    = 46;
    localparam int REQ_ID_LSB    = 48;
    localparam int REQ_ID_MSB    = 63;
    localparam int TAG_LSB       = 64;
    localparam int TAG_MSB       = 71;
    localparam int CPL_ID_LSB    = 72;
    localparam int CPL_ID_MSB    = 87;
    localparam int CPL_ID_EN_BIT = 88;
    localparam int TC_LSB        = 89;
    localparam int TC_MSB        = 91;
    localparam int ATTR_LSB      = 92;
    localparam int ATTR_MSB      = 94;
    localparam int PAYLOAD_LSB   = 96;
    localparam int PAYLOAD_MSB   = 127;

    // is_sop0 (bit 0), is_eop0 (bit 6), eop0_ptr = 3 (bits 11:8)
    localparam logic [80:0] CC_TUSER_SINGLE = 81'h341;

    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  orig_tag;
        logic [2:0]  attr;
        logic [2:0]  tc;
    } trk_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic logic [DESC_W-1:0] build_cc_desc(input logic [DESC_W-1:0] rc,
                                                         input trk_entry_t       e);
        logic [DESC_W-1:0] cc;
        cc = '0;
        cc[BC_MSB:BC_LSB]           = rc[BC_MSB:BC_LSB];
        cc[DWC_MSB:DWC_LSB]         = rc[DWC_MSB:DWC_LSB];
        cc[STATUS_MSB:STATUS_LSB]   = rc[STATUS_MSB:STATUS_LSB];
        cc[POISON_BIT]              = rc[POISON_BIT];
        cc[REQ_ID_MSB:REQ_ID_LSB]   = e.req_id;
        cc[TAG_MSB:TAG_LSB]         = e.orig_tag;
        cc[CPL_ID_MSB:CPL_ID_LSB]   = rc[CPL_ID_MSB:CPL_ID_LSB];
        cc[CPL_ID_EN_BIT]           = 1'b1;
        cc[TC_MSB:TC_LSB]           = e.tc;
        cc[ATTR_MSB:ATTR_LSB]       = e.attr;
        // Only a single-dword completion carries data worth forwarding
        if (rc[DWC_MSB:DWC_LSB] == 11'd1)
            cc[PAYLOAD_MSB:PAYLOAD_LSB] = rc[PAYLOAD_MSB:PAYLOAD_LSB];
        return cc;
    endfunction

endpackage

// File: rtl/cfg_fwd_tag_table.sv
// Tracking table indexed by the DSP RQ tag: valid bits, saved requester context,
// and a count of live entries.
module cfg_fwd_tag_table
    import cfg_fwd_pkg::*;
#(
    parameter int TAG_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  trk_entry_t          wr_entry,
    input  logic [TAG_BITS-1:0] chk_tag,
    output logic                chk_valid,
    input  logic [TAG_BITS-1:0] rd_tag,
    output logic                rd_valid,
    output trk_entry_t          rd_entry,
    input  logic                clr_en,
    input  logic [TAG_BITS-1:0] clr_tag,
    output logic [TAG_BITS:0]   outstanding
);

    localparam int DEPTH = 1 << TAG_BITS;

    logic [DEPTH-1:0] valid_q;
    trk_entry_t       entry_q [DEPTH];
    logic             clr_hit;

    // A clear of an already-free slot is a no-op and must not touch the count
    assign clr_hit   = clr_en && valid_q[clr_tag];
    assign chk_valid = valid_q[chk_tag];
    assign rd_valid  = valid_q[rd_tag];
    assign rd_entry  = entry_q[rd_tag];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            outstanding <= '0;
        end else begin
            if (clr_hit)
                valid_q[clr_tag] <= 1'b0;
            if (wr_en)
                valid_q[wr_tag] <= 1'b1;
            case ({wr_en, clr_hit})
                2'b10:   outstanding <= outstanding + (TAG_BITS+1)'(1);
                2'b01:   outstanding <= outstanding - (TAG_BITS+1)'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            entry_q[wr_tag] <= wr_entry;
    end

endmodule

// File: rtl/cfg_cpl_return_forwarder.sv
// Turns single-beat DSP RC completions for forwarded cfg requests into USP CC
// completions carrying the original requester ID, tag, TC and attributes.
module cfg_cpl_return_forwarder
    import cfg_fwd_pkg::*;
#(
    parameter int IF_WIDTH       = 512,
    parameter int TKEEP_WIDTH    = 16,
    parameter int RC_TUSER_WIDTH = 161,
    parameter int CC_TUSER_WIDTH = 81,
    parameter int TAG_BITS       = 5
) (
    input  logic                      user_clk,
    input  logic                      user_reset_n,
    input  logic                      trk_valid,
    output logic                      trk_ready,
    input  logic [TAG_BITS-1:0]       trk_tag,
    input  logic [15:0]               trk_req_id,
    input  logic [7:0]                trk_orig_tag,
    input  logic [2:0]                trk_attr,
    input  logic [2:0]                trk_tc,
    input  logic [IF_WIDTH-1:0]       m_axis_rc_tdata,
    input  logic [TKEEP_WIDTH-1:0]    m_axis_rc_tkeep,
    input  logic                      m_axis_rc_tlast,
    input  logic [RC_TUSER_WIDTH-1:0] m_axis_rc_tuser,
    input  logic                      m_axis_rc_tvalid,
    output logic                      m_axis_rc_tready,
    output logic [IF_WIDTH-1:0]       s_axis_cc_tdata,
    output logic [TKEEP_WIDTH-1:0]    s_axis_cc_tkeep,
    output logic                      s_axis_cc_tlast,
    output logic [CC_TUSER_WIDTH-1:0] s_axis_cc_tuser,
    output logic                      s_axis_cc_tvalid,
    input  logic                      s_axis_cc_tready,
    output logic                      orphan_cpl,
    output logic                      malformed_cpl,
    output logic [TAG_BITS:0]         outstanding,
    output state_t                    state_dbg
);

    // Handshakes: a beat transfers on a rising edge where valid && ready; a
    // source never drops valid or changes payload until that transfer happens.

    state_t              state;
    trk_entry_t          trk_entry;
    trk_entry_t          rd_entry;
    logic                chk_valid;
    logic                rd_valid;
    logic                rc_fire;
    logic [7:0]          rc_tag;
    logic [TAG_BITS-1:0] rc_idx;
    logic                tag_in_range;
    logic                hit;
    logic                wr_en;
    logic                clr_en;
    logic                unused_rc;

    assign trk_entry    = '{req_id: trk_req_id, orig_tag: trk_orig_tag, attr: trk_attr, tc: trk_tc};
    assign rc_tag       = m_axis_rc_tdata[TAG_MSB:TAG_LSB];
    assign rc_idx       = rc_tag[TAG_BITS-1:0];
    assign tag_in_range = (rc_tag >> TAG_BITS) == 8'd0;
    assign hit          = tag_in_range && rd_valid;

    assign trk_ready        = user_reset_n && !chk_valid;
    assign m_axis_rc_tready = user_reset_n && (state != HOLD);
    assign rc_fire          = m_axis_rc_tvalid && m_axis_rc_tready;
    assign wr_en            = trk_valid && trk_ready;
    // Retire on a good completion, drop the slot on a malformed one; the table
    // ignores clears of slots that are not valid, so orphans fall through harmlessly
    assign clr_en           = (state == IDLE) && rc_fire && tag_in_range;
    assign state_dbg        = state;

    assign unused_rc = ^{m_axis_rc_tdata, m_axis_rc_tkeep, m_axis_rc_tuser};

    cfg_fwd_tag_table #(
        .TAG_BITS(TAG_BITS)
    ) u_tag_table (
        .clk        (user_clk),
        .rst_n      (user_reset_n),
        .wr_en      (wr_en),
        .wr_tag     (trk_tag),
        .wr_entry   (trk_entry),
        .chk_tag    (trk_tag),
        .chk_valid  (chk_valid),
        .rd_tag     (rc_idx),
        .rd_valid   (rd_valid),
        .rd_entry   (rd_entry),
        .clr_en     (clr_en),
        .clr_tag    (rc_idx),
        .outstanding(outstanding)
    );

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state            <= IDLE;
            s_axis_cc_tvalid <= 1'b0;
            s_axis_cc_tdata  <= '0;
            s_axis_cc_tkeep  <= '0;
            s_axis_cc_tlast  <= 1'b0;
            s_axis_cc_tuser  <= '0;
            orphan_cpl       <= 1'b0;
            malformed_cpl    <= 1'b0;
        end else begin
            orphan_cpl    <= 1'b0;
            malformed_cpl <= 1'b0;
            case (state)
                IDLE: begin
                    if (rc_fire) begin
                        if (!m_axis_rc_tlast) begin
                            malformed_cpl <= 1'b1;
                            state         <= DROP;
                        end else if (hit) begin
                            s_axis_cc_tdata  <= IF_WIDTH'(build_cc_desc(m_axis_rc_tdata[DESC_W-1:0], rd_entry));
                            s_axis_cc_tkeep  <= TKEEP_WIDTH'(16'h000F);
                            s_axis_cc_tlast  <= 1'b1;
                            s_axis_cc_tuser  <= CC_TUSER_WIDTH'(CC_TUSER_SINGLE);
                            s_axis_cc_tvalid <= 1'b1;
                            state            <= HOLD;
                        end else begin
                            orphan_cpl <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (s_axis_cc_tready) begin
                        s_axis_cc_tvalid <= 1'b0;
                        state            <= IDLE;
                    end
                end
                DROP: begin
                    if (rc_fire && m_axis_rc_tlast)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_cpl_return_forwarder.sv
// Directed bench for cfg_cpl_return_forwarder: hand-built RC completions in,
// hand-computed CC descriptors and status outputs expected.
module tb_cfg_cpl_return_forwarder;
    import cfg_fwd_pkg::*;

    logic         user_clk;
    logic         user_reset_n;
    logic         trk_valid;
    logic         trk_ready;
    logic [4:0]   trk_tag;
    logic [15:0]  trk_req_id;
    logic [7:0]   trk_orig_tag;
    logic [2:0]   trk_attr;
    logic [2:0]   trk_tc;
    logic [511:0] rc_tdata;
    logic [15:0]  rc_tkeep;
    logic         rc_tlast;
    logic [160:0] rc_tuser;
    logic         rc_tvalid;
    logic         rc_tready;
    logic [511:0] cc_tdata;
    logic [15:0]  cc_tkeep;
    logic         cc_tlast;
    logic [80:0]  cc_tuser;
    logic         cc_tvalid;
    logic         cc_tready;
    logic         orphan_cpl;
    logic         malformed_cpl;
    logic [5:0]   outstanding;
    state_t       state_dbg;

    int checks = 0;
    int errors = 0;

    logic [511:0] rc1, cc1, rc_orph, rc_upper, rc_mal, rc_ur, cc_ur, held;
    logic [31:0]  free_vec;

    cfg_cpl_return_forwarder dut (
        .user_clk        (user_clk),
        .user_reset_n    (user_reset_n),
        .trk_valid       (trk_valid),
        .trk_ready       (trk_ready),
        .trk_tag         (trk_tag),
        .trk_req_id      (trk_req_id),
        .trk_orig_tag    (trk_orig_tag),
        .trk_attr        (trk_attr),
        .trk_tc          (trk_tc),
        .m_axis_rc_tdata (rc_tdata),
        .m_axis_rc_tkeep (rc_tkeep),
        .m_axis_rc_tlast (rc_tlast),
        .m_axis_rc_tuser (rc_tuser),
        .m_axis_rc_tvalid(rc_tvalid),
        .m_axis_rc_tready(rc_tready),
        .s_axis_cc_tdata (cc_tdata),
        .s_axis_cc_tkeep (cc_tkeep),
        .s_axis_cc_tlast (cc_tlast),
        .s_axis_cc_tuser (cc_tuser),
        .s_axis_cc_tvalid(cc_tvalid),
        .s_axis_cc_tready(cc_tready),
        .orphan_cpl      (orphan_cpl),
        .malformed_cpl   (malformed_cpl),
        .outstanding     (outstanding),
        .state_dbg       (state_dbg)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        rc1      = {{12{32'hDEADBEEF}}, 32'h10EE9034, 32'h00000803, 32'hBEEF0001, 32'h00040004};
        cc1      = {384'h0, 32'h10EE9034, 32'h0100082A, 32'h01000001, 32'h00040000};
        rc_orph  = {384'h0, 32'h0, 32'h00000807, 32'h00000001, 32'h00040000};
        rc_upper = {384'h0, 32'h0, 32'h00000826, 32'h00000001, 32'h00040000};
        rc_mal   = {384'h0, 32'h0, 32'h00000805, 32'h00000001, 32'h00040000};
        rc_ur    = {{12{32'h12345678}}, 32'hFFFFFFFF, 32'h00030009, 32'h00004800, 32'h00000000};
        cc_ur    = {384'h0, 32'h00000000, 32'h2B030011, 32'hABCD4800, 32'h00000000};

        user_reset_n = 1'b0;
        trk_valid    = 1'b0;
        trk_tag      = '0;
        trk_req_id   = '0;
        trk_orig_tag = '0;
        trk_attr     = '0;
        trk_tc       = '0;
        rc_tdata     = '0;
        rc_tkeep     = 16'h000F;
        rc_tlast     = 1'b0;
        rc_tuser     = '0;
        rc_tvalid    = 1'b0;
        cc_tready    = 1'b0;

        // Reset state
        repeat (3) @(posedge user_clk);
        #1;
        check("rst_rc_tready", rc_tready, 0);
        check("rst_trk_ready", trk_ready, 0);
        check("rst_cc_tvalid", cc_tvalid, 0);
        check("rst_cc_tdata", cc_tdata, 0);
        check("rst_cc_tuser", cc_tuser, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_pulses", {orphan_cpl, malformed_cpl}, 0);
        user_reset_n = 1'b1;
        #1;
        check("post_rst_rc_tready", rc_tready, 1);
        check("post_rst_trk_ready", trk_ready, 1);

        // Track tag 3, then complete it while tag 6 is captured in the same cycle
        trk_valid    = 1'b1;
        trk_tag      = 5'd3;
        trk_req_id   = 16'h0100;
        trk_orig_tag = 8'h2A;
        tick();
        trk_valid = 1'b0;
        #1;
        check("t1_outstanding_1", outstanding, 1);
        check("t1_tag3_busy", trk_ready, 0);
        rc_tdata     = rc1;
        rc_tlast     = 1'b1;
        rc_tvalid    = 1'b1;
        trk_valid    = 1'b1;
        trk_tag      = 5'd6;
        trk_req_id   = 16'h0600;
        trk_orig_tag = 8'h66;
        #1;
        check("t1_tag6_free", trk_ready, 1);
        check("t1_rc_tready_idle", rc_tready, 1);
        tick();
        rc_tvalid = 1'b0;
        trk_valid = 1'b0;
        check("t1_cc_tvalid", cc_tvalid, 1);
        check("t1_cc_tdata", cc_tdata, cc1);
        check("t1_cc_tkeep", cc_tkeep, 16'h000F);
        check("t1_cc_tlast", cc_tlast, 1);
        check("t1_cc_tuser", cc_tuser, 81'h341);
        check("t1_outstanding_net", outstanding, 1);
        check("t1_rc_tready_hold", rc_tready, 0);
        check("t1_state_hold", state_dbg, HOLD);
        trk_tag = 5'd3;
        #1;
        check("t1_tag3_freed", trk_ready, 1);

        // Back-pressure for 10 cycles: beat must stay put
        held = cc_tdata;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_tvalid", cc_tvalid, 1);
            check("stall_tdata", cc_tdata, held);
            check("stall_rc_tready", rc_tready, 0);
        end
        cc_tready = 1'b1;
        tick();
        cc_tready = 1'b0;
        check("release_tvalid", cc_tvalid, 0);
        check("release_rc_tready", rc_tready, 1);
        check("release_state", state_dbg, IDLE);

        // Orphan: untracked tag 7
        rc_tdata  = rc_orph;
        rc_tlast  = 1'b1;
        rc_tvalid = 1'b1;
        tick();
        rc_tvalid = 1'b0;
        check("orph_pulse", orphan_cpl, 1);
        check("orph_no_cc", cc_tvalid, 0);
        check("orph_rc_tready", rc_tready, 1);
        tick();
        check("orph_pulse_end", orphan_cpl, 0);

        // Orphan: tag 8'h26 has upper bits set although slot 6 is live
        rc_tdata  = rc_upper;
        rc_tvalid = 1'b1;
        tick();
        rc_tvalid = 1'b0;
        check("upper_orph_pulse", orphan_cpl, 1);
        check("upper_orph_no_cc", cc_tvalid, 0);
        check("upper_orph_outstanding", outstanding, 1);

        // Malformed: two-beat completion on tracked tag 5
        trk_valid    = 1'b1;
        trk_tag      = 5'd5;
        trk_req_id   = 16'h0500;
        trk_orig_tag = 8'h55;
        tick();
        trk_valid = 1'b0;
        check("mal_outstanding_2", outstanding, 2);
        rc_tdata  = rc_mal;
        rc_tlast  = 1'b0;
        rc_tvalid = 1'b1;
        tick();
        check("mal_pulse", malformed_cpl, 1);
        check("mal_outstanding_1", outstanding, 1);
        check("mal_state_drop", state_dbg, DROP);
        check("mal_rc_tready_drop", rc_tready, 1);
        rc_tlast = 1'b1;
        tick();
        rc_tvalid = 1'b0;
        check("mal_pulse_end", malformed_cpl, 0);
        check("mal_no_cc", cc_tvalid, 0);
        check("mal_no_orphan", orphan_cpl, 0);
        check("mal_state_idle", state_dbg, IDLE);
        trk_tag = 5'd5;
        #1;
        check("mal_tag5_free", trk_ready, 1);

        // Fill every slot
        trk_req_id   = 16'hABCD;
        trk_orig_tag = 8'h11;
        trk_tc       = 3'd5;
        trk_attr     = 3'd2;
        for (int t = 0; t < 32; t++) begin
            trk_valid = 1'b1;
            trk_tag   = 5'(t);
            tick();
        end
        trk_valid = 1'b0;
        check("fill_outstanding", outstanding, 32);
        for (int t = 0; t < 32; t++) begin
            trk_tag = 5'(t);
            #1;
            free_vec[t] = trk_ready;
        end
        check("fill_none_free", free_vec, 32'h0);

        // UR completion with poison on tag 9, left pending in HOLD
        rc_tdata  = rc_ur;
        rc_tlast  = 1'b1;
        rc_tvalid = 1'b1;
        tick();
        rc_tvalid = 1'b0;
        check("ur_cc_tvalid", cc_tvalid, 1);
        check("ur_cc_tdata", cc_tdata, cc_ur);
        check("ur_outstanding", outstanding, 31);
        tick();
        check("ur_still_hold", state_dbg, HOLD);

        // Reset in HOLD drops the pending beat and empties the table
        user_reset_n = 1'b0;
        #1;
        check("hold_rst_tvalid", cc_tvalid, 0);
        check("hold_rst_tdata", cc_tdata, 0);
        check("hold_rst_outstanding", outstanding, 0);
        check("hold_rst_rc_tready", rc_tready, 0);
        check("hold_rst_trk_ready", trk_ready, 0);
        tick();
        user_reset_n = 1'b1;
        for (int t = 0; t < 32; t++) begin
            trk_tag = 5'(t);
            #1;
            free_vec[t] = trk_ready;
        end
        check("after_rst_all_free", free_vec, 32'hFFFF_FFFF);
        check("after_rst_state", state_dbg, IDLE);
        check("after_rst_tvalid", cc_tvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_cpl_return_forwarder.md
Name: cfg_cpl_return_forwarder

Overview:
- Return path for configuration requests that the USP forwards to the DSP as Type 0 RQ requests.
- Records each forwarded request's original requester ID and tag, indexed by the RQ tag.
- Accepts the single-beat completion on the DSP RC interface and rebuilds it as a CC completion for the CPM5 USP, restoring the original requester ID and tag.
- Sits between the DSP RC AXI-S and the USP CC AXI-S.

Parameters:
IF_WIDTH, 512, AXI-S data width
TKEEP_WIDTH, 16, dword keep width
RC_TUSER_WIDTH, 161, RC tuser width
CC_TUSER_WIDTH, 81, CC tuser width
TAG_BITS, 5, log2 of the number of tracking entries; RQ tags used are 0..2^TAG_BITS-1

Ports:
user_clk  in  1  clock
user_reset_n  in  1  asynchronous active-low reset
trk_valid  in  1  forwarded cfg request issued
trk_ready  out  1  tracking slot for trk_tag is free
trk_tag  in  TAG_BITS  RQ tag used on the DSP
trk_req_id  in  16  original requester ID (from CQ)
trk_orig_tag  in  8  original CQ tag
trk_attr  in  3  original attributes
trk_tc  in  3  original traffic class
m_axis_rc_tdata / tkeep / tlast / tuser / tvalid  in  IF_WIDTH / TKEEP_WIDTH / 1 / RC_TUSER_WIDTH / 1  DSP RC stream
m_axis_rc_tready  out  1
s_axis_cc_tdata / tkeep / tlast / tuser / tvalid  out  IF_WIDTH / TKEEP_WIDTH / 1 / CC_TUSER_WIDTH / 1  USP CC stream
s_axis_cc_tready  in  1
orphan_cpl  out  1  one-cycle pulse: completion with untracked tag dropped
malformed_cpl  out  1  one-cycle pulse: multi-beat completion dropped
outstanding  out  TAG_BITS+1  count of valid tracking entries

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all valid bits 0; outstanding=0; state IDLE
  - s_axis_cc_tvalid=0; cc tdata/tkeep/tlast/tuser=0
  - m_axis_rc_tready=0 while reset is asserted
  - pulses=0; trk_ready=0 while reset is asserted
- Tracking: trk_ready = !valid[trk_tag] (combinational). On trk_valid&trk_ready, the entry is written at the next edge and valid is set.
- RC field extraction: tag [71:64], status [45:43], byte count [28:16], dword count [42:32], completer ID [87:72], error code [15:12], payload [127:96]. Only the lower TAG_BITS of the tag index the table; upper tag bits nonzero → orphan.
- FSM:
  - IDLE: m_axis_rc_tready=1.
    - On an accepted beat with tlast=1 and tag valid: build the CC beat into the output register, clear valid[tag], go to HOLD.
    - tlast=1 and tag invalid: pulse orphan_cpl, stay IDLE.
    - tlast=0: pulse malformed_cpl and clear valid[tag] if set, go DROP.
  - HOLD: m_axis_rc_tready=0; s_axis_cc_tvalid=1. On s_axis_cc_tready: tvalid drops and state returns to IDLE at the next edge. No back-to-back bypass; throughput is 1 completion per 2 cycles minimum.
  - DROP: m_axis_rc_tready=1; discard beats until an accepted tlast, then go IDLE.
- CC beat:
  - lower addr [6:0]=0; AT [9:8]=0
  - byte count [28:16] and dword count [42:32] copied from RC
  - locked [29]=0; status [45:43] copied; poisoned [46]=RC poisoned
  - requester ID [63:48]=trk_req_id; tag [71:64]=trk_orig_tag
  - completer ID [87:72] copied; completer ID enable [88]=1
  - TC [91:89]=trk_tc; attr [94:92]=trk_attr; force ECRC [95]=0
  - payload [127:96] copied when dword count=1, else 0; bits above 127 = 0
  - tkeep=16'h000F; tlast=1; tuser=CC_TUSER_SINGLE constant (is_sop0=1, is_eop0=1, eop0_ptr=3)
- Latency: RC accept → CC tvalid is 1 cycle. The output is held stable until tready; tvalid never drops without a handshake.
- Simultaneous events:
  - A completion retiring tag T and a trk capture of T in the same cycle cannot occur, because trk_ready is 0 while T is valid.
  - A retire of T and a capture of U≠T in the same cycle are both applied. outstanding is updated by +1, −1, or net 0.
- Reset mid-HOLD discards the pending CC beat with no partial output.

Decomposition:
- Package cfg_fwd_pkg holds:
  - RC/CC descriptor field bit-position localparams
  - trk_entry_t struct {req_id, orig_tag, attr, tc}
  - state enum {IDLE, HOLD, DROP}
  - CC_TUSER_SINGLE constant
- One sub-module, cfg_fwd_tag_table: valid vector plus entry RAM (registers), write port, lookup port and clear port, and the outstanding counter.

Test Plan:
- Track tag 3 (req_id 16'h0100, orig_tag 8'h2A, tc 0, attr 0). RC cpl tag 3, status SC, dword count 1, payload 32'h10EE_9034 → one CC beat 1 cycle later with req_id 0100, tag 2A, byte count 4, tkeep 000F, payload 10EE9034; outstanding 1→0.
- RC cpl with tag 7 while untracked → orphan_cpl pulses once; no CC beat; rc tready stays 1.
- CC tready held 0 for 10 cycles during HOLD → tvalid and data stable; rc tready=0 throughout; release → transfer, then IDLE.
- Two-beat RC packet on tracked tag 5 → malformed_cpl pulse, valid[5] cleared, both beats consumed, no CC output.
- UR completion (status 3'b001, dword count 0) on tracked tag → CC status 001, dword count 0, payload 0.
- Fill all 32 tags → trk_ready=0 for any tag; outstanding=32. Assert reset while in HOLD → CC tvalid=0 immediately, outstanding=0, all tags free after deassert.
